// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the single-port data memory between two requesters
// Each access takes one IDLE cycle and one SERVE cycle; read data and error flags are registered.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rw
);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t state, state_n;
  logic   ptr;
  logic   in0, in1;

  assign in0 = (addr0[ADDR_W-1:MEM_AW] == '0);
  assign in1 = (addr1[ADDR_W-1:MEM_AW] == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state   <= state_n;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      case (state)
        SERVE0: begin
          ptr <= 1'b1;
          // In-range writes complete silently; everything else returns a response
          if (!we0 || !in0) begin
            rvalid0 <= 1'b1;
            err0    <= !in0;
            rdata0  <= in0 ? mem_rdata : '0;
          end
        end
        SERVE1: begin
          ptr <= 1'b0;
          if (!we1 || !in1) begin
            rvalid1 <= 1'b1;
            err1    <= !in1;
            rdata1  <= in1 ? mem_rdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rw    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_n = ptr ? SERVE1 : SERVE0;
        else if (req0)
          state_n = SERVE0;
        else if (req1)
          state_n = SERVE1;
      end
      SERVE0: begin
        ack0      = 1'b1;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        // Gated by Reset so an access interrupted by reset never lands
        mem_rw    = we0 & in0 & ~Reset;
        state_n   = IDLE;
      end
      SERVE1: begin
        ack1      = 1'b1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_rw    = we1 & in1 & ~Reset;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        ack0, ack1, rvalid0, rvalid1, err0, err1, mem_rw;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 Clock = ~Clock;

  dmem_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rw(mem_rw)
  );

  // Memory the arbiter drives: combinational read, clocked write, power-on contents = index
  assign mem_rdata = mem_rw ? 32'h0 : mem[mem_addr[4:0]];
  always @(posedge Clock) if (mem_rw) mem[mem_addr[4:0]] <= mem_wdata;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = i;
      ref_mem[i] = i;
    end
    addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit inr(input logic [31:0] a);
    return a < 32;
  endfunction

  // Transaction-level model: which port is being served this cycle, who was served last,
  // and the responses due next cycle.
  int          m_srv = -1;
  int          m_last = 1;
  logic [1:0]  m_rv = '0;
  logic [1:0]  m_err = '0;
  logic [31:0] m_rd [2] = '{32'h0, 32'h0};

  always @(negedge Clock) begin
    logic        e_rw;
    logic [31:0] e_addr, e_wdata;
    int          s;
    e_rw = 1'b0; e_addr = 0; e_wdata = 0;
    if (m_srv >= 0) begin
      e_addr  = addr[m_srv];
      e_wdata = wdata[m_srv];
      e_rw    = we[m_srv] && inr(addr[m_srv]) && !Reset;
    end
    if (chk_en) begin
      chk("ack0", ack0, m_srv == 0);
      chk("ack1", ack1, m_srv == 1);
      chk("mem_rw", mem_rw, e_rw);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("rvalid0", rvalid0, m_rv[0]);
      chk("rvalid1", rvalid1, m_rv[1]);
      if (m_rv[0]) chk("err0", err0, m_err[0]);
      if (m_rv[1]) chk("err1", err1, m_err[1]);
      chk("rdata0", rdata0, m_rd[0]);
      chk("rdata1", rdata1, m_rd[1]);
    end
    if (Reset) begin
      m_srv = -1; m_last = 1; m_rv = '0; m_err = '0; m_rd[0] = 0; m_rd[1] = 0;
    end else if (m_srv >= 0) begin
      s = m_srv;
      m_rv = '0;
      if (!inr(addr[s])) begin
        m_rv[s] = 1'b1; m_err[s] = 1'b1; m_rd[s] = 0;
      end else if (we[s]) begin
        ref_mem[addr[s][4:0]] = wdata[s];
      end else begin
        m_rv[s] = 1'b1; m_err[s] = 1'b0; m_rd[s] = ref_mem[addr[s][4:0]];
      end
      m_last = s;
      m_srv = -1;
    end else begin
      m_rv = '0;
      if (req == 2'b11) m_srv = 1 - m_last;
      else if (req[0]) m_srv = 0;
      else if (req[1]) m_srv = 1;
    end
  end

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
  endtask

  // Issue one access from an IDLE cycle; returns cycles to ack and the response that follows
  task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic rv, output logic er, output logic [31:0] rd);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    lat = 0;
    @(negedge Clock);
    while (!(p == 0 ? ack0 : ack1) && lat < 10) begin
      step(); lat++; @(negedge Clock);
    end
    if (lat >= 10) begin
      total++; bad++;
      $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", p);
    end
    step();
    req[p] = 1'b0;
    @(negedge Clock);
    rv = (p == 0) ? rvalid0 : rvalid1;
    er = (p == 0) ? err0 : err1;
    rd = (p == 0) ? rdata0 : rdata1;
    step();
  endtask

  initial begin
    int          lat;
    logic        rv, er;
    logic [31:0] rd;
    logic [8:0]  s0, s1, r1;
    logic [2:0]  p0;
    logic [1:0]  seen;

    reset_dut();
    chk_en = 1'b1;
    chk("reset_rdata0", rdata0, 0);
    chk("reset_rvalid1", rvalid1, 0);

    // 1: write then read back on port 0
    access(0, 1'b1, 3, 32'hDEAD_BEEF, lat, rv, er, rd);
    chk("t1_wr_lat", lat, 1);
    chk("t1_wr_norv", rv, 0);
    access(0, 1'b0, 3, 0, lat, rv, er, rd);
    chk("t1_rd_lat", lat, 1);
    chk("t1_rd_rv", rv, 1);
    chk("t1_rd_err", er, 0);
    chk("t1_rd_data", rd, 32'hDEAD_BEEF);

    // 2: both ports held, strict alternation starting with port 0
    reset_dut();
    req = 2'b11; we = 2'b00; addr[0] = 1; addr[1] = 2;
    s0 = '0; s1 = '0;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) req[1] = 1'b0;
      @(negedge Clock);
      s0[c] = ack0; s1[c] = ack1;
      step();
    end
    chk("t2_ack0_seq", s0, 9'b000100010);
    chk("t2_ack1_seq", s1, 9'b010001000);
    chk("t2_rdata0", rdata0, 1);
    chk("t2_rdata1", rdata1, 2);
    step();
    req[0] = 1'b0;
    step();

    // 3: out-of-range write must not alias onto word 0
    access(1, 1'b1, 32'h20, 32'h1234_5678, lat, rv, er, rd);
    chk("t3_rv", rv, 1);
    chk("t3_err", er, 1);
    chk("t3_rdata", rd, 0);
    chk("t3_mem0", mem[0], 0);
    access(1, 1'b0, 0, 0, lat, rv, er, rd);
    chk("t3_reread", rd, 0);
    chk("t3_reread_err", er, 0);

    // 4: reset during the serve cycle of a write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5; wdata[0] = 32'h55;
    step();
    Reset = 1'b1;
    @(negedge Clock);
    chk("t4_ack0", ack0, 1);
    chk("t4_mem_rw", mem_rw, 0);
    step();
    Reset = 1'b0; req[0] = 1'b0;
    @(negedge Clock);
    chk("t4_no_rvalid", rvalid0, 0);
    step();
    access(0, 1'b0, 5, 0, lat, rv, er, rd);
    chk("t4_mem5", rd, 5);

    // 5: port 1 streaming reads, port 0 idle
    reset_dut();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 7;
    s1 = '0; r1 = '0; p0 = '0;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) req[1] = 1'b0;
      @(negedge Clock);
      s1[c] = ack1; r1[c] = rvalid1; p0 = p0 | {ack0, rvalid0, |rdata0};
      step();
    end
    chk("t5_ack1_seq", s1, 9'b010101010);
    chk("t5_rvalid1_seq", r1, 9'b101010100);
    chk("t5_rdata1", rdata1, 7);
    chk("t5_port0_quiet", p0, 0);

    // 6: port 0 arrives while port 1 is being served
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 7;
    s0 = '0; s1 = '0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin req[0] = 1'b1; we[0] = 1'b0; addr[0] = 2; end
      if (c == 2) req[1] = 1'b0;
      if (c == 4) req[0] = 1'b0;
      @(negedge Clock);
      s0[c] = ack0; s1[c] = ack1;
      step();
    end
    chk("t6_ack1", s1[4:0], 5'b00010);
    chk("t6_ack0", s0[4:0], 5'b01000);

    // Randomized traffic with occasional resets, checked by the model every cycle
    seen = '0;
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom % 50 == 0);
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || seen[p]) begin
          if ($urandom % 3 != 0) begin
            req[p] = 1'b1;
            we[p] = $urandom % 2;
            addr[p] = ($urandom % 6 == 0) ? ($urandom_range(31, 0) | (32'h1 << $urandom_range(31, 5)))
                                          : $urandom_range(31, 0);
            wdata[p] = $urandom;
          end else begin
            req[p] = 1'b0;
          end
        end
      end
      @(negedge Clock);
      seen = {ack1, ack0};
      step();
    end
    Reset = 1'b0; req = '0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
